// File: rtl/pipeline_pkg.sv
// Shared types and default sizing for the pipeline stall/flush controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN
    } stall_state_e;

    localparam int DEF_NUM_STAGES   = 4;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_WD_LIMIT     = 1024;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall merge, bubble insertion, flush sequencing, per-stage stall
// counters and retire-hang watchdog for an in-order pipeline.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int NUM_STAGES   = DEF_NUM_STAGES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int WD_LIMIT     = DEF_WD_LIMIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_STAGES-1:0]       stall_req,
    input  logic                        flush_req,
    input  logic                        mem_busy,
    input  logic                        perf_clr,
    output logic [NUM_STAGES-1:0]       stall,
    output logic [NUM_STAGES-1:0]       bubble,
    output logic [NUM_STAGES-1:0]       flush,
    output logic                        flushing,
    output logic [NUM_STAGES*CNT_W-1:0] stall_cnt,
    output logic                        hang,
    output logic                        hang_flag
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WDW = $clog2(WD_LIMIT + 1);
    localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(WD_LIMIT);
    localparam logic [WDW-1:0] WD_PRE  = WDW'(WD_LIMIT - 1);

    stall_state_e          state;
    logic [FCW-1:0]        fcnt;
    logic [WDW-1:0]        wd;
    logic [NUM_STAGES-1:0] merged;

    // An older (higher-index) stage blocking holds every younger stage too.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        merged = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc       = acc | stall_req[i];
            merged[i] = acc;
        end
    end

    always_comb begin
        stall  = merged;
        bubble = '0;
        flush  = '0;
        if (!reset) begin
            stall = '1;
        end else begin
            unique case (state)
                IDLE: begin
                    for (int i = 0; i < NUM_STAGES - 1; i++) begin
                        bubble[i+1] = merged[i] & ~merged[i+1];
                    end
                end
                FLUSH: begin
                    stall = '1;
                    flush = '1;
                end
                DRAIN: begin
                    stall = '1;
                end
                default: ;
            endcase
        end
    end

    assign flushing = reset && (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                        fcnt  <= FC_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_req) begin
                        fcnt <= FC_LOAD;
                    end else if (fcnt == '0) begin
                        state <= mem_busy ? DRAIN : IDLE;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (flush_req) begin
                        state <= FLUSH;
                        fcnt  <= FC_LOAD;
                    end else if (!mem_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pulse only on the step into WD_LIMIT; wd parks there afterwards.
    assign hang = reset && !perf_clr && stall[NUM_STAGES-1] && (wd == WD_PRE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd        <= '0;
            hang_flag <= 1'b0;
        end else if (perf_clr) begin
            wd        <= '0;
            hang_flag <= 1'b0;
        end else if (!stall[NUM_STAGES-1]) begin
            wd <= '0;
        end else begin
            if (wd != WD_MAX) begin
                wd <= wd + 1'b1;
            end
            if (hang) begin
                hang_flag <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cnt
        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (stall[g]),
            .clr  (perf_clr),
            .cnt  (stall_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (N=4, CNT_W=4, FLUSH_CYCLES=2, WD_LIMIT=8).
module tb_pipeline_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  stall_req;
    logic        flush_req;
    logic        mem_busy;
    logic        perf_clr;
    logic [3:0]  stall;
    logic [3:0]  bubble;
    logic [3:0]  flush;
    logic        flushing;
    logic [15:0] stall_cnt;
    logic        hang;
    logic        hang_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    pipeline_stall_ctrl #(
        .NUM_STAGES  (4),
        .CNT_W       (4),
        .FLUSH_CYCLES(2),
        .WD_LIMIT    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall_req(stall_req),
        .flush_req(flush_req),
        .mem_busy (mem_busy),
        .perf_clr (perf_clr),
        .stall    (stall),
        .bubble   (bubble),
        .flush    (flush),
        .flushing (flushing),
        .stall_cnt(stall_cnt),
        .hang     (hang),
        .hang_flag(hang_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic want(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic got(input logic [31:0] o);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow observed=%h expected=none", o);
        end else begin
            x = sb.pop_front();
            assert (o === x.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b0;
        stall_req = 4'b0000;
        flush_req = 1'b0;
        mem_busy  = 1'b0;
        perf_clr  = 1'b0;
        tick();
        tick();

        want("rst_stall", 32'hF);     got(32'(stall));
        want("rst_flush", 32'h0);     got(32'(flush));
        want("rst_flushing", 32'h0);  got(32'(flushing));
        want("rst_cnt", 32'h0);       got(32'(stall_cnt));
        want("rst_hflag", 32'h0);     got(32'(hang_flag));
        reset = 1'b1;
        settle();
        want("rel_stall", 32'h0);     got(32'(stall));

        // stall merge and bubble patterns
        tick();
        stall_req = 4'b0100;
        settle();
        want("m0100_stall", 32'h7);   got(32'(stall));
        want("m0100_bubble", 32'h8);  got(32'(bubble));
        tick();
        stall_req = 4'b0000;
        settle();
        want("m0100_cnt", 32'h0111);  got(32'(stall_cnt));
        want("idle_stall", 32'h0);    got(32'(stall));
        tick();
        stall_req = 4'b0001;
        settle();
        want("m0001_stall", 32'h1);   got(32'(stall));
        want("m0001_bubble", 32'h2);  got(32'(bubble));
        tick();
        stall_req = 4'b1010;
        settle();
        want("m1010_stall", 32'hF);   got(32'(stall));
        want("m1010_bubble", 32'h0);  got(32'(bubble));
        tick();
        stall_req = 4'b0000;
        settle();
        want("mix_cnt", 32'h1223);    got(32'(stall_cnt));

        // single flush, mem idle
        tick();
        stall_req = 4'b0010;
        flush_req = 1'b1;
        settle();
        want("freq_stall", 32'h3);    got(32'(stall));
        want("freq_flush", 32'h0);    got(32'(flush));
        tick();
        stall_req = 4'b0000;
        flush_req = 1'b0;
        settle();
        want("f1_flush", 32'hF);      got(32'(flush));
        want("f1_stall", 32'hF);      got(32'(stall));
        want("f1_bubble", 32'h0);     got(32'(bubble));
        want("f1_flushing", 32'h1);   got(32'(flushing));
        tick();
        settle();
        want("f2_flush", 32'hF);      got(32'(flush));
        tick();
        settle();
        want("f3_flushing", 32'h0);   got(32'(flushing));
        want("f3_flush", 32'h0);      got(32'(flush));
        want("f3_stall", 32'h0);      got(32'(stall));
        want("flush_cnt", 32'h3456);  got(32'(stall_cnt));

        // flush with memory busy -> drain, restart from drain
        tick();
        flush_req = 1'b1;
        mem_busy  = 1'b1;
        settle();
        want("d0_flushing", 32'h0);   got(32'(flushing));
        tick();
        flush_req = 1'b0;
        settle();
        want("d1_flush", 32'hF);      got(32'(flush));
        tick();
        settle();
        want("d2_flush", 32'hF);      got(32'(flush));
        tick();
        settle();
        want("dr_flush", 32'h0);      got(32'(flush));
        want("dr_stall", 32'hF);      got(32'(stall));
        want("dr_flushing", 32'h1);   got(32'(flushing));
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            want("dr_hold_stall", 32'hF); got(32'(stall));
            want("dr_hold_flush", 32'h0); got(32'(flush));
        end
        flush_req = 1'b1;
        settle();
        want("dr_req_flush", 32'h0);  got(32'(flush));
        tick();
        flush_req = 1'b0;
        settle();
        want("rs1_flush", 32'hF);     got(32'(flush));
        tick();
        settle();
        want("rs2_flush", 32'hF);     got(32'(flush));
        tick();
        settle();
        want("dr2_flush", 32'h0);     got(32'(flush));
        want("dr2_flushing", 32'h1);  got(32'(flushing));
        mem_busy = 1'b0;
        settle();
        want("dr2_last", 32'h1);      got(32'(flushing));
        tick();
        settle();
        want("dr_exit_fl", 32'h0);    got(32'(flushing));
        want("dr_exit_st", 32'h0);    got(32'(stall));

        // reset asserted mid-flush
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        settle();
        want("mf_flush", 32'hF);      got(32'(flush));
        reset = 1'b0;
        settle();
        want("mr_stall", 32'hF);      got(32'(stall));
        want("mr_flush", 32'h0);      got(32'(flush));
        want("mr_flushing", 32'h0);   got(32'(flushing));
        want("mr_cnt", 32'h0);        got(32'(stall_cnt));
        tick();
        reset = 1'b1;
        settle();
        want("mrel_flush", 32'h0);    got(32'(flush));
        want("mrel_stall", 32'h0);    got(32'(stall));
        tick();
        settle();
        want("mrel2_fl", 32'h0);      got(32'(flushing));

        // retire watchdog
        tick();
        stall_req = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) tick();
            settle();
            want($sformatf("wd_hang_%0d", k), 32'(k == 8));
            got(32'(hang));
            want($sformatf("wd_flag_%0d", k), 32'(k >= 9));
            got(32'(hang_flag));
        end
        perf_clr = 1'b1;
        settle();
        want("clr_flag_hold", 32'h1); got(32'(hang_flag));
        tick();
        perf_clr = 1'b0;
        settle();
        want("clr_flag", 32'h0);      got(32'(hang_flag));
        want("clr_hang", 32'h0);      got(32'(hang));
        repeat (7) tick();
        perf_clr = 1'b1;
        settle();
        want("clr_win_hang", 32'h0);  got(32'(hang));
        tick();
        perf_clr = 1'b0;
        settle();
        want("clr_win_flag", 32'h0);  got(32'(hang_flag));
        repeat (4) tick();
        stall_req = 4'b0000;
        tick();
        stall_req = 4'b1000;
        repeat (6) tick();
        settle();
        want("wdclr_d7", 32'h0);      got(32'(hang));
        tick();
        settle();
        want("wdclr_d8", 32'h1);      got(32'(hang));
        stall_req = 4'b0000;
        perf_clr  = 1'b1;
        tick();
        perf_clr = 1'b0;

        // counter saturation and clear priority
        stall_req = 4'b0001;
        settle();
        want("sat_start", 32'h0);     got(32'(stall_cnt));
        repeat (15) tick();
        settle();
        want("sat_15", 32'hF);        got(32'(stall_cnt[3:0]));
        repeat (5) tick();
        settle();
        want("sat_hold", 32'h000F);   got(32'(stall_cnt));
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        settle();
        want("sat_clr", 32'h0);       got(32'(stall_cnt));
        tick();
        settle();
        want("sat_after", 32'h1);     got(32'(stall_cnt));
        stall_req = 4'b0000;

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
